// File: rtl/corefifo_gray_conv_pipe.sv
// Pipelined binary<->Gray pointer converter with a valid/ready handshake and an
// optional checker that flags Gray words moving by more than one bit.
module corefifo_gray_conv_pipe #(
    parameter int ADDRWIDTH   = 3,
    parameter int PIPE_STAGES = 2,
    parameter int CHECK_STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [ADDRWIDTH:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDRWIDTH:0] out_data,
    output logic               out_mode,
    output logic               step_err
);
    localparam int W    = ADDRWIDTH + 1;
    localparam int LAST = PIPE_STAGES - 1;

    // Handshake: a word moves across an interface on a rising edge where valid and
    // ready are both 1; valid never waits for ready, ready may depend on downstream.

    logic [PIPE_STAGES-1:0] stg_valid;
    logic [PIPE_STAGES-1:0] stg_mode;
    logic [PIPE_STAGES-1:0] stg_err;
    logic [PIPE_STAGES-1:0] stg_load;
    logic [W-1:0]           stg_data [PIPE_STAGES];

    logic [W-1:0] conv_data;
    logic         in_fire;
    logic         in_err;

    logic         has_prev;
    logic         prev_mode;
    logic [W-1:0] prev_gray;

    // A stage may load when it is empty or its word leaves this cycle; the chain
    // runs from the output back so a full pipeline still streams with no bubble.
    always_comb begin : load_chain
        logic downstream_free;
        stg_load        = '0;
        downstream_free = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            downstream_free = !stg_valid[k] || downstream_free;
            stg_load[k]     = downstream_free;
        end
    end

    assign in_ready = stg_load[0] && !reset;
    assign in_fire  = in_valid && in_ready;

    always_comb begin : convert
        logic acc;
        conv_data = '0;
        acc       = 1'b0;
        if (in_mode) begin
            acc                  = in_data[ADDRWIDTH];
            conv_data[ADDRWIDTH] = acc;
            for (int i = ADDRWIDTH - 1; i >= 0; i--) begin
                acc          = acc ^ in_data[i];
                conv_data[i] = acc;
            end
        end else begin
            conv_data = in_data ^ (in_data >> 1);
        end
    end

    // More than one differing bit means clearing the lowest set bit leaves a residue.
    always_comb begin : step_check
        logic [W-1:0] diff;
        diff   = in_data ^ prev_gray;
        in_err = (CHECK_STEP != 0) && in_mode && has_prev && prev_mode
                 && ((diff & (diff - W'(1))) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            stg_mode  <= '0;
            stg_err   <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stg_data[k] <= '0;
            end
            has_prev  <= 1'b0;
            prev_mode <= 1'b0;
            prev_gray <= '0;
        end else begin
            if (in_fire) begin
                has_prev  <= 1'b1;
                prev_mode <= in_mode;
                prev_gray <= in_data;
            end
            if (stg_load[0]) begin
                stg_valid[0] <= in_fire;
                if (in_fire) begin
                    stg_data[0] <= conv_data;
                    stg_mode[0] <= in_mode;
                    stg_err[0]  <= in_err;
                end
            end
            // Payload only moves with a valid word so the output holds when idle.
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (stg_load[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) begin
                        stg_data[k] <= stg_data[k-1];
                        stg_mode[k] <= stg_mode[k-1];
                        stg_err[k]  <= stg_err[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = stg_valid[LAST];
    assign out_data  = stg_data[LAST];
    assign out_mode  = stg_mode[LAST];
    assign step_err  = stg_valid[LAST] && stg_err[LAST];

endmodule

// File: tb/tb_corefifo_gray_conv_pipe.sv
// Directed and random checks of the Gray converter pipeline, including a wide
// four-stage build and a one-bit single-stage build.
module tb_corefifo_gray_conv_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- main DUT (3, 2, 1) ----------------
    logic       in_valid, in_mode, in_ready;
    logic [3:0] in_data, out_data;
    logic       out_valid, out_mode, step_err;
    logic       fixed_ready, rnd_en;
    logic       rnd_ready = 1'b0;
    logic       out_ready;
    assign out_ready = rnd_en ? rnd_ready : fixed_ready;

    corefifo_gray_conv_pipe #(.ADDRWIDTH(3), .PIPE_STAGES(2), .CHECK_STEP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .step_err(step_err)
    );

    // ---------------- wide build (15, 4, 0) ----------------
    logic        b_in_valid, b_in_mode, b_in_ready, b_out_valid, b_out_mode, b_step_err;
    logic [15:0] b_in_data, b_out_data;

    corefifo_gray_conv_pipe #(.ADDRWIDTH(15), .PIPE_STAGES(4), .CHECK_STEP(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(1'b1), .out_data(b_out_data), .out_mode(b_out_mode),
        .step_err(b_step_err)
    );

    // ---------------- one-bit build (0, 1, 1) ----------------
    logic       c_in_valid, c_in_mode, c_in_ready, c_out_valid, c_out_mode, c_step_err;
    logic [0:0] c_in_data, c_out_data;

    corefifo_gray_conv_pipe #(.ADDRWIDTH(0), .PIPE_STAGES(1), .CHECK_STEP(1)) dut_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_mode(c_in_mode), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(1'b1), .out_data(c_out_data), .out_mode(c_out_mode),
        .step_err(c_step_err)
    );

    always begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard: {err, mode, data} ----------------
    logic [5:0] exp_q[$];

    task automatic expect_word(input logic m, input logic [3:0] d, input logic e);
        exp_q.push_back({e, m, d});
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {26'd0, step_err, out_mode, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("sb_word", {26'd0, step_err, out_mode, out_data}, {26'd0, e});
            end
        end
    end

    // ---------------- reference model for random traffic ----------------
    logic       m_has, m_mode;
    logic [3:0] m_prev;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic model_push(input logic m, input logic [3:0] d);
        logic [3:0] o;
        logic       e;
        o = m ? g2b(d) : (d ^ (d >> 1));
        e = m && m_has && m_mode && ($countones(d ^ m_prev) > 1);
        expect_word(m, o, e);
        m_has  = 1'b1;
        m_mode = m;
        m_prev = d;
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic m, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (!in_ready && n < 100) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_has  = 1'b0;
        m_mode = 1'b0;
        m_prev = 4'd0;
    endtask

    task automatic run_b(input logic m, input logic [15:0] d, input logic [15:0] e);
        int lat;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_mode  = m;
        b_in_data  = d;
        check("b_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (b_out_valid) begin
                lat = k;
                break;
            end
        end
        check("b_latency", 32'(lat), 32'd4);
        check("b_data", {16'd0, b_out_data}, {16'd0, e});
        check("b_step_err", 32'(b_step_err), 32'd0);
    endtask

    task automatic run_c(input logic m, input logic d, input logic e);
        int lat;
        @(negedge clk);
        c_in_valid = 1'b1;
        c_in_mode  = m;
        c_in_data  = d;
        check("c_in_ready", 32'(c_in_ready), 32'd1);
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (c_out_valid) begin
                lat = k;
                break;
            end
        end
        check("c_latency", 32'(lat), 32'd1);
        check("c_data", 32'(c_out_data), 32'(e));
        check("c_mode", 32'(c_out_mode), 32'(m));
        check("c_step_err", 32'(c_step_err), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
        logic       err;
    } vec_t;

    vec_t       vecs [13];
    logic [3:0] bp [4];

    initial begin
        #200000;
        check("watchdog", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         idx;
        logic       acc;
        logic [3:0] bv;

        vecs[0]  = '{1'b1, 4'b1101, 4'b1001, 1'b0};
        vecs[1]  = '{1'b0, 4'b1001, 4'b1101, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 4'b0001, 4'b0001, 1'b0};
        vecs[4]  = '{1'b1, 4'b0011, 4'b0010, 1'b0};
        vecs[5]  = '{1'b1, 4'b0110, 4'b0100, 1'b1};
        vecs[6]  = '{1'b1, 4'b0100, 4'b0111, 1'b0};
        vecs[7]  = '{1'b1, 4'b1000, 4'b1111, 1'b1};
        vecs[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[9]  = '{1'b1, 4'b0011, 4'b0010, 1'b1};
        vecs[10] = '{1'b0, 4'b0101, 4'b0111, 1'b0};
        vecs[11] = '{1'b1, 4'b0110, 4'b0100, 1'b0};
        vecs[12] = '{1'b1, 4'b0111, 4'b0101, 1'b0};
        bp[0] = 4'd1; bp[1] = 4'd2; bp[2] = 4'd3; bp[3] = 4'd4;

        reset = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = 4'd0;
        fixed_ready = 1'b1; rnd_en = 1'b0;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = 16'd0;
        c_in_valid = 1'b0; c_in_mode = 1'b0; c_in_data = 1'b0;
        m_has = 1'b0; m_mode = 1'b0; m_prev = 4'd0;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_mode", 32'(out_mode), 32'd0);
        check("rst_step_err", 32'(step_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Latency of one Gray-to-binary word.
        expect_word(1'b1, 4'b1001, 1'b0);
        send(1'b1, 4'b1101);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_cycle2_data", 32'(out_data), 32'b1001);
        check("lat_cycle2_mode", 32'(out_mode), 32'd1);
        drain(50);

        // Directed conversion and step-checker table, streamed back to back.
        pulse_reset();
        for (int i = 0; i < 13; i++) begin
            expect_word(vecs[i].mode, vecs[i].dout, vecs[i].err);
            send(vecs[i].mode, vecs[i].din);
        end
        drain(50);

        // Round trip: binary 0..15 to Gray, then those Gray words back to binary.
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            bv = 4'(i);
            expect_word(1'b0, bv ^ (bv >> 1), 1'b0);
            send(1'b0, bv);
        end
        for (int i = 0; i < 16; i++) begin
            bv = 4'(i);
            expect_word(1'b1, bv, 1'b0);
            send(1'b1, bv ^ (bv >> 1));
        end
        drain(50);
        check("roundtrip_stalls", 32'(stalls), 32'd0);

        // Backpressure: output stalled for five cycles with input offered throughout.
        for (int i = 0; i < 4; i++) expect_word(1'b0, bp[i] ^ (bp[i] >> 1), 1'b0);
        fixed_ready = 1'b0;
        idx = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mode  = 1'b0;
            in_data  = bp[idx];
            check("bp_in_ready", 32'(in_ready), 32'(c <= 2));
            if (c >= 3) begin
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_out_data_stable", 32'(out_data), 32'b0001);
            end
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd2);
        fixed_ready = 1'b1;
        send(1'b0, bp[2]);
        send(1'b0, bp[3]);
        drain(50);

        // Reset with two words in flight, then a 3-bit Gray jump is not flagged.
        fixed_ready = 1'b0;
        send(1'b1, 4'b0000);
        send(1'b1, 4'b0001);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_step_err", 32'(step_err), 32'd0);
        check("mid_rst_in_ready_rel", 32'(in_ready), 32'd1);
        fixed_ready = 1'b1;
        expect_word(1'b1, 4'b1010, 1'b0);
        send(1'b1, 4'b1111);
        drain(50);
        repeat (4) @(negedge clk);

        // Random words with random output backpressure.
        pulse_reset();
        rnd_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic       m;
            logic [3:0] d;
            m = 1'($urandom_range(0, 1));
            d = 4'($urandom_range(0, 15));
            model_push(m, d);
            send(m, d);
        end
        drain(2000);
        rnd_en = 1'b0;

        // Other builds: latency equals stage count; checker disabled on the wide one.
        run_b(1'b1, 16'h0000, 16'h0000);
        run_b(1'b1, 16'hFFFF, 16'hAAAA);
        run_b(1'b0, 16'h8001, 16'hC001);
        run_c(1'b0, 1'b1, 1'b1);
        run_c(1'b1, 1'b1, 1'b1);
        run_c(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
